// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop.
// Operands are processed LSB-first, one bit per clock, over WIDTH cycles.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Handshake: start is accepted only in IDLE; done pulses for exactly one
  // cycle when sum/co are updated, and those hold until the next accepted start.
  state_t state, state_nxt;

  logic [WIDTH-1:0] ra, rb, rs;
  logic             c, rsub;
  logic [CW-1:0]    count;
  logic             s, c_nxt, last;

  assign s     = ra[0] ^ rb[0] ^ c;
  assign c_nxt = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
  assign last  = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: state_nxt = start ? ADD : IDLE;
      ADD: begin
        busy      = 1'b1;
        state_nxt = last ? DONE : ADD;
      end
      DONE: done = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      c     <= 1'b0;
      rsub  <= 1'b0;
      count <= '0;
      sum   <= '0;
      co    <= 1'b0;
    end else if (state == IDLE && start) begin
      // Subtraction is a + ~b + 1: the +1 rides in on the carry flip-flop.
      ra    <= a;
      rb    <= sub ? ~b : b;
      c     <= sub;
      rsub  <= sub;
      count <= '0;
    end else if (state == ADD) begin
      ra    <= {1'b0, ra[WIDTH-1:1]};
      rb    <= {1'b0, rb[WIDTH-1:1]};
      rs    <= {s, rs[WIDTH-1:1]};
      c     <= c_nxt;
      count <= count + CW'(1);
      if (last) begin
        sum <= {s, rs[WIDTH-1:1]};
        co  <= c_nxt ^ rsub;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8) plus an exhaustive WIDTH=4 sweep
// against an arithmetic reference.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, sub;
  logic [7:0] a, b, sum;
  logic       co, busy, done;

  logic       start4, sub4;
  logic [3:0] a4, b4, sum4;
  logic       co4, busy4, done4;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] prev_sum = 8'h00;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .sum(sum), .co(co), .busy(busy), .done(done)
  );

  serial_addsub #(.WIDTH(4), .CW(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .sum(sum4), .co(co4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the IDLE return, so the
  // next call's start lands in the first cycle after DONE.
  // mode 0: clean, 1: stray start pulses at E3, E8 and in DONE, 2: inputs churn.
  task automatic run_op(input string tag, input logic s_in, input logic [7:0] a_in,
                        input logic [7:0] b_in, input logic [7:0] exp_sum,
                        input logic exp_co, input int mode);
    int edges;
    int busy_cnt;
    start = 1'b1; sub = s_in; a = a_in; b = b_in;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    busy_cnt = 0;
    check({tag, " sum_hold"}, {24'h0, sum}, {24'h0, prev_sum});
    while (!done && edges < 20) begin
      if (busy) busy_cnt++;
      if (mode == 1) start = (edges == 2 || edges == 7);
      if (mode == 1) begin a = 8'hFF; b = 8'hFF; end
      if (mode == 2) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        sub = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      edges++;
    end
    check({tag, " latency"}, edges, 8);
    check({tag, " busy_cycles"}, busy_cnt, 8);
    check({tag, " busy_in_done"}, {31'h0, busy}, 32'h0);
    check({tag, " sum"}, {24'h0, sum}, {24'h0, exp_sum});
    check({tag, " co"}, {31'h0, co}, {31'h0, exp_co});
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_one_cycle"}, {31'h0, done}, 32'h0);
    check({tag, " idle_after"}, {31'h0, busy}, 32'h0);
    prev_sum = exp_sum;
  endtask

  initial begin
    int seen;
    int off;
    logic [4:0] exp4;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    #2;
    check("reset_outputs", {sum, co, busy, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1_add", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 0);
    run_op("t2_carry", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 0);
    run_op("t2_zero", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 0);
    run_op("t3_sub", 1'b1, 8'h10, 8'h01, 8'h0F, 1'b0, 0);
    run_op("t3_borrow", 1'b1, 8'h01, 8'h02, 8'hFF, 1'b1, 0);
    run_op("t3_equal", 1'b1, 8'h80, 8'h80, 8'h00, 1'b0, 0);
    run_op("t4_ignore", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1);
    run_op("t4_next", 1'b0, 8'h20, 8'h03, 8'h23, 1'b0, 0);

    // Reset in the middle of an operation.
    start = 1'b1; sub = 1'b0; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_sum", {24'h0, sum}, 32'h0);
    check("t5_rst_co", {31'h0, co}, 32'h0);
    check("t5_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("t5_no_done", seen, 0);
    prev_sum = 8'h00;
    run_op("t5_after", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 0);

    run_op("t6_churn_add", 1'b0, 8'hC3, 8'h5E, 8'h21, 1'b1, 2);
    run_op("t6_churn_sub", 1'b1, 8'h37, 8'h9C, 8'h9B, 1'b1, 2);

    // Exhaustive WIDTH=4 sweep in a shuffled order (odd stride is a bijection mod 512).
    off = $urandom_range(0, 511);
    for (int i = 0; i < 512; i++) begin
      int idx;
      int cyc;
      idx = (i * 167 + off) % 512;
      sub4 = idx[8]; a4 = idx[7:4]; b4 = idx[3:0];
      if (sub4) exp4 = {(a4 < b4), 4'(a4 - b4)};
      else      exp4 = 5'(a4) + 5'(b4);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      a4 = ~a4; b4 = ~b4; sub4 = ~sub4;
      cyc = 0;
      while (!done4 && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      check($sformatf("w4 op=%0d a=%0h b=%0h", idx[8], idx[7:4], idx[3:0]),
            {27'h0, co4, sum4}, {27'h0, exp4});
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial adder/subtractor: accepts two WIDTH-bit operands on a start strobe and processes them LSB-first, one bit per clock, using a single full-adder cell plus a carry flip-flop.
- Pairs with the combinational full_subtractor/half_subtractor cells: the same carry/borrow chain, but folded in time for area-constrained datapaths.
- Result, carry/borrow flag and a one-cycle done pulse are presented after WIDTH cycles.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).
- CW, 4, width of the internal bit counter; must satisfy 2**CW >= WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  operation select sampled with start: 0 = a+b, 1 = a-b.
- a  input  WIDTH  first operand (minuend when sub=1), sampled with start.
- b  input  WIDTH  second operand (subtrahend when sub=1), sampled with start.
- sum  output  WIDTH  result register; valid from done until the next accepted start.
- co  output  1  add: carry-out; sub: borrow-out (1 when a < b, unsigned).
- busy  output  1  high while in ADD state.
- done  output  1  one-cycle pulse when sum/co become valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; sum = 0, co = 0, busy = 0, done = 0.
  - Shift registers, carry flip-flop and counter cleared.
  - Takes effect immediately, including mid-operation; the partial result is discarded and no done pulse is issued.
- States: IDLE, ADD, DONE (2-bit encoding, no illegal-state lockup; unused code goes to IDLE).
- IDLE, start=1 at edge E0:
  - Load ra = a.
  - Load rb = b when sub=0, or rb = ~b when sub=1.
  - Carry flip-flop c = sub (injects +1 for two's complement).
  - Latch sub into rsub; count = 0; go to ADD.
  - sum and co are not altered at load; they hold the previous result until DONE.
- IDLE, start=0: remain in IDLE; all outputs hold.
- ADD, each edge:
  - s = ra[0] ^ rb[0] ^ c.
  - c <= majority(ra[0], rb[0], c).
  - ra, rb shift right by one.
  - Internal result shift register rs shifts right with s inserted at the MSB.
  - count increments.
- ADD exit: on the edge where count == WIDTH-1 (the WIDTH-th ADD edge, E_WIDTH), go to DONE.
  - sum <= final rs, i.e. the shifted value including that edge's bit.
  - co <= c_final ^ rsub, so a sub result with no borrow gives co = 0.
- busy = 1 exactly during ADD, i.e. from E0 to E_WIDTH, which is WIDTH cycles.
- DONE:
  - done = 1 for exactly one cycle (E_WIDTH to E_WIDTH+1), busy = 0.
  - Unconditional return to IDLE on the next edge.
  - start is ignored in DONE.
- Latency: done is high in the cycle beginning WIDTH edges after the start-sampling edge.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start asserted in ADD or DONE: ignored, with no effect on operands, sub or the result.
- Operands and sub may change freely after E0 with no effect on the running operation.
- Arithmetic is modulo 2**WIDTH.
  - Add: {co, sum} = a + b.
  - Sub: sum = a - b (two's complement); co = 1 iff a < b unsigned.

Test Plan:
1. WIDTH=8, sub=0, a=0x5A, b=0x3C, start one cycle -> busy high 8 cycles, done pulse 8 edges after start; sum=0x96, co=0.
2. sub=0, a=0xFF, b=0x01 -> sum=0x00, co=1. Then a=0x00, b=0x00 -> sum=0x00, co=0 (no carry leaking from the prior run).
3. sub=1, a=0x10, b=0x01 -> sum=0x0F, co=0. Then sub=1, a=0x01, b=0x02 -> sum=0xFF, co=1. Then sub=1, a=b=0x80 -> sum=0x00, co=0.
4. Start 0x12+0x34, then pulse start with a=0xFF, b=0xFF at cycles 3 and 8 after the first start -> single done pulse with sum=0x46, co=0; the extra pulses are ignored. A start in the cycle after DONE is accepted normally.
5. Start 0xAA+0x55, drop rst_n at cycle 4 for 1 cycle -> immediately sum=0, co=0, busy=0; no done pulse. Then a new 0x01+0x01 -> sum=0x02.
6. Change a, b and sub on every cycle during ADD -> the result matches the operands captured at the start edge. Exhaustive randomized add/sub over WIDTH=4 (all 512 cases) -> matches the reference model.
